// File: rtl/i2c_target_model.sv
// Simulation-side 24Cxx-style I2C register-file target. Oversamples SCL/SDA on clk_i
// and answers on SDA through an open-drain pull-low enable; SCL is never stretched.
module i2c_target_model #(
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int         MemDepth   = 16,
    parameter logic [7:0] MemInit    = 8'h00
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_pd_o,
    output logic                        busy_o,
    output logic                        wr_valid_o,
    output logic [$clog2(MemDepth)-1:0] wr_addr_o,
    output logic [7:0]                  wr_data_o
);
    localparam int AW = $clog2(MemDepth);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_PTR, S_WR, S_RD, S_RD_ACK, S_ACK, S_IGNORE
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_c, stop_c;

    state_t          state, state_n, tgt, tgt_n;
    logic [3:0]      cnt, cnt_n;
    logic [6:0]      shreg, shreg_n;
    logic [AW-1:0]   ptr, ptr_n;
    logic            pd_n, busy_n, we;
    logic [7:0]      byte_in;
    logic [7:0]      mem [MemDepth];

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in  = {shreg, sda_s};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            tgt   <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            ptr   <= ptr_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sda_pd_o   <= 1'b0;
            busy_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            for (int i = 0; i < MemDepth; i++) mem[i] <= MemInit;
        end else begin
            sda_pd_o   <= pd_n;
            busy_o     <= busy_n;
            wr_valid_o <= we;
            if (we) begin
                wr_addr_o <= ptr;
                wr_data_o <= byte_in;
                mem[ptr]  <= byte_in;
            end
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        cnt_n   = cnt;
        shreg_n = shreg;
        ptr_n   = ptr;
        pd_n    = sda_pd_o;
        busy_n  = busy_o;
        we      = 1'b0;
        if (stop_c) begin
            state_n = S_IDLE;
            pd_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_c) begin
            state_n = S_ADDR;
            cnt_n   = '0;
            pd_n    = 1'b0;
            busy_n  = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_IGNORE: pd_n = 1'b0;
                S_ADDR, S_PTR, S_WR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in[6:0];
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            state_n = S_ACK;
                            if (state == S_ADDR) begin
                                if (shreg == TargetAddr) tgt_n = sda_s ? S_RD : S_PTR;
                                else                     state_n = S_IGNORE;
                            end else if (state == S_PTR) begin
                                ptr_n = byte_in[AW-1:0];
                                tgt_n = S_WR;
                            end else begin
                                // Commit on the 8th rising edge so a STOP in the ACK slot keeps the byte.
                                we    = 1'b1;
                                ptr_n = ptr + 1'b1;
                                tgt_n = S_WR;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (scl_fall) begin
                        if (!sda_pd_o) begin
                            pd_n = 1'b1;
                        end else if (tgt == S_RD) begin
                            pd_n    = ~mem[ptr][7];
                            cnt_n   = 4'd1;
                            state_n = S_RD;
                        end else begin
                            pd_n    = 1'b0;
                            state_n = tgt;
                        end
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            pd_n    = 1'b0;
                            ptr_n   = ptr + 1'b1;
                            cnt_n   = '0;
                            state_n = S_RD_ACK;
                        end else begin
                            pd_n  = ~mem[ptr][~cnt[2:0]];
                            cnt_n = cnt + 4'd1;
                        end
                    end
                end
                S_RD_ACK: if (scl_rise) state_n = sda_s ? S_IGNORE : S_RD;
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target_model.sv
// Directed bench: an I2C host drives the model over a wired-AND SDA and checks
// ACK slots, read data, write pulses and the pull-down timing.
module tb_i2c_target_model;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       host_scl, host_sda;
    logic       sda_line;
    logic       sda_pd, busy, wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [11:0] wq[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    assign sda_line = host_sda & ~sda_pd;

    i2c_target_model #(.TargetAddr(7'h50), .MemDepth(16), .MemInit(8'h00)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .scl_i(host_scl), .sda_i(sda_line),
        .sda_pd_o(sda_pd), .busy_o(busy), .wr_valid_o(wr_valid),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    always @(negedge clk) if (wr_valid) wq.push_back({wr_addr, wr_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        host_sda = b; tick(T);
        host_scl = 1'b1; tick(T);
        host_scl = 1'b0; tick(T);
    endtask

    task automatic read_bit(output logic b);
        host_sda = 1'b1; tick(T);
        host_scl = 1'b1; tick(T/2);
        b = sda_line; tick(T/2);
        host_scl = 1'b0; tick(T);
    endtask

    task automatic start_c();
        host_sda = 1'b1; tick(T);
        host_scl = 1'b1; tick(T);
        host_sda = 1'b0; tick(T);
        host_scl = 1'b0; tick(T);
    endtask

    task automatic stop_c();
        host_sda = 1'b0; tick(T);
        host_scl = 1'b1; tick(T);
        host_sda = 1'b1; tick(T);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // START, 0xA0, ptr, repeated START, 0xA1 -- leaves the model ready to send data
    task automatic open_read(input logic [7:0] p, input string tag);
        logic a;
        start_c();
        write_byte(8'hA0, a); chk({tag, "_ack_wa"}, 32'(a), 0);
        write_byte(p, a);     chk({tag, "_ack_ptr"}, 32'(a), 0);
        start_c();
        write_byte(8'hA1, a); chk({tag, "_ack_ra"}, 32'(a), 0);
    endtask

    initial begin
        logic       a, b;
        logic [7:0] d;
        rst_ni = 1'b0; host_scl = 1'b1; host_sda = 1'b1;
        tick(3);
        chk("rst_pd", 32'(sda_pd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wrv", 32'(wr_valid), 0);
        chk("rst_wra", 32'(wr_addr), 0);
        chk("rst_wrd", 32'(wr_data), 0);
        rst_ni = 1'b1; tick(3);

        // 1: write 0xA5,0x5A at 3; measure ACK pull-down latency on the address byte
        start_c();
        chk("busy_start", 32'(busy), 1);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hA0 >> i));
        host_sda = 1'b0; tick(T);
        host_scl = 1'b1; tick(T);
        host_scl = 1'b0; tick(2);
        chk("pd_lat2", 32'(sda_pd), 0);
        tick(1);
        chk("pd_lat3", 32'(sda_pd), 1);
        tick(T - 3);
        read_bit(a);  chk("t1_ack_addr", 32'(a), 0);
        write_byte(8'h03, a); chk("t1_ack_ptr", 32'(a), 0);
        write_byte(8'hA5, a); chk("t1_ack_d0", 32'(a), 0);
        write_byte(8'h5A, a); chk("t1_ack_d1", 32'(a), 0);
        stop_c();
        chk("t1_wcount", 32'(wq.size()), 2);
        if (wq.size() == 2) begin
            chk("t1_w0", 32'(wq[0]), 32'h3A5);
            chk("t1_w1", 32'(wq[1]), 32'h45A);
        end
        open_read(8'h03, "t1r");
        read_byte(1'b0, d); chk("t1_rd0", 32'(d), 32'hA5);
        read_byte(1'b1, d); chk("t1_rd1", 32'(d), 32'h5A);
        stop_c();
        chk("t1_busy_stop", 32'(busy), 0);

        // 2: wrong address is ignored
        start_c();
        write_byte(8'hB0, a); chk("t2_nack_addr", 32'(a), 1);
        write_byte(8'h11, a); chk("t2_nack_data", 32'(a), 1);
        stop_c();
        chk("t2_wcount", 32'(wq.size()), 2);

        // 3: pointer wrap on write and read
        start_c();
        write_byte(8'hA0, a); chk("t3_ack_addr", 32'(a), 0);
        write_byte(8'h0F, a); chk("t3_ack_ptr", 32'(a), 0);
        write_byte(8'h01, a); chk("t3_ack_d0", 32'(a), 0);
        write_byte(8'h02, a); chk("t3_ack_d1", 32'(a), 0);
        stop_c();
        chk("t3_wcount", 32'(wq.size()), 4);
        if (wq.size() == 4) begin
            chk("t3_w0", 32'(wq[2]), 32'hF01);
            chk("t3_w1", 32'(wq[3]), 32'h002);
        end
        open_read(8'h0F, "t3r");
        read_byte(1'b0, d); chk("t3_rd15", 32'(d), 32'h01);
        read_byte(1'b0, d); chk("t3_rd0", 32'(d), 32'h02);
        read_byte(1'b1, d); chk("t3_rd1", 32'(d), 32'h00);
        stop_c();

        // 4: STOP after 4 data bits discards the byte
        start_c();
        write_byte(8'hA0, a); chk("t4_ack_addr", 32'(a), 0);
        write_byte(8'h05, a); chk("t4_ack_ptr", 32'(a), 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        stop_c();
        chk("t4_pd", 32'(sda_pd), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_wcount", 32'(wq.size()), 4);
        open_read(8'h05, "t4r");
        read_byte(1'b1, d); chk("t4_rd5", 32'(d), 32'h00);
        stop_c();

        // 6: NACK then repeated START continues at the incremented pointer
        open_read(8'h0F, "t6r");
        read_byte(1'b1, d); chk("t6_rd15", 32'(d), 32'h01);
        start_c();
        write_byte(8'hA1, a); chk("t6_ack_ra2", 32'(a), 0);
        read_byte(1'b1, d); chk("t6_rd0", 32'(d), 32'h02);
        stop_c();

        // 5: reset while the model is pulling SDA low during a read bit
        open_read(8'h03, "t5r");
        read_bit(b);  chk("t5_bit7", 32'(b), 1);
        chk("t5_pd_bit6", 32'(sda_pd), 1);
        rst_ni = 1'b0; #1;
        chk("t5_pd_rst", 32'(sda_pd), 0);
        chk("t5_busy_rst", 32'(busy), 0);
        tick(2);
        rst_ni = 1'b1; tick(3);
        stop_c();
        start_c();
        write_byte(8'hA1, a); chk("t5_ack_ra", 32'(a), 0);
        read_byte(1'b1, d); chk("t5_rd_ptr0", 32'(d), 32'h00);
        stop_c();
        open_read(8'h03, "t5m");
        read_byte(1'b1, d); chk("t5_rd3", 32'(d), 32'h00);
        stop_c();
        chk("t5_wcount", 32'(wq.size()), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
